// File: rtl/fetch_pc_gen_pkg.sv
// Shared definitions for the fetch PC generator: address bus type, FSM state encodings, reset/exception vectors.
// Latency: n/a (types and constants only).  Backpressure: n/a.
package fetch_pc_gen_pkg;

   localparam int ADDR_BUS = 32;
   typedef logic [ADDR_BUS-1:0] addr_t;

   localparam addr_t PC_RESET_DEFAULT   = 32'hBFC0_0000;
   localparam addr_t EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

   typedef enum logic [1:0] {
      PC_STATE_IDLE  = 2'd0,
      PC_STATE_FETCH = 2'd1,
      PC_STATE_HOLD  = 2'd2
   } pc_state_e;

   // Which next-PC rule won this cycle; SRC_NONE means the PC holds.
   typedef enum logic [2:0] {
      SRC_NONE   = 3'd0,
      SRC_FLUSH  = 3'd1,
      SRC_PEND   = 3'd2,
      SRC_BRANCH = 3'd3,
      SRC_SEQ    = 3'd4
   } pc_src_e;

   function automatic logic addr_misaligned(input addr_t a);
      return |a[1:0];
   endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Fetch-side bundle: hazard/exception controls in, ROM address and IF/ID PC out.
// Latency: n/a (wiring only).  Backpressure: stall / inst_ready hold the PC.
interface fetch_pc_gen_if;
   import fetch_pc_gen_pkg::*;

   logic  stall;
   logic  inst_ready;
   logic  branch_flag;
   addr_t branch_addr;
   logic  flush;
   addr_t flush_pc;

   logic  rom_en;
   addr_t rom_addr;
   addr_t pc;
   logic  pc_valid;
   logic  pending;
   logic  addr_err;
   addr_t bad_addr;

   modport master (
      input  stall, inst_ready, branch_flag, branch_addr, flush, flush_pc,
      output rom_en, rom_addr, pc, pc_valid, pending, addr_err, bad_addr
   );

   modport slave (
      output stall, inst_ready, branch_flag, branch_addr, flush, flush_pc,
      input  rom_en, rom_addr, pc, pc_valid, pending, addr_err, bad_addr
   );

endinterface

// File: rtl/fetch_pc_gen_branch_latch.sv
// Single-entry redirect buffer: captures a branch target while fetch is held.
// Latency: 1 cycle set-to-visible.  Backpressure: a held entry is never overwritten; clear beats set.
module branch_latch
   import fetch_pc_gen_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  set,
   input  addr_t set_addr,
   input  logic  clear,
   output logic  pending,
   output addr_t pend_addr
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending   <= 1'b0;
         pend_addr <= '0;
      end else if (clear) begin
         pending   <= 1'b0;
      end else if (set && !pending) begin
         // ID re-asserts the same branch every stalled cycle, so the first capture is kept.
         pending   <= 1'b1;
         pend_addr <= set_addr;
      end
   end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator with single-delay-slot redirect and a buffered redirect across holds; optional PC_ALIGN_CHECK_EN.
// Latency: branch sampled at edge N drives rom_addr=branch_addr in cycle N+1 when advancing.
// Backpressure: stall or !inst_ready holds the PC; a redirect seen during the hold is buffered.
module fetch_pc_gen
   import fetch_pc_gen_pkg::*;
#(
   parameter addr_t RESET_PC   = PC_RESET_DEFAULT,
   parameter addr_t EXC_VECTOR = EXC_VECTOR_DEFAULT
)(
   input  logic           clk,
   input  logic           rst,
   fetch_pc_gen_if.master bus
);

   pc_state_e state;
   addr_t     pc_q;
   logic      rom_en_q;
   logic      pending;
   addr_t     pend_addr;

   logic      running;
   logic      advance;
   pc_src_e   src;
   addr_t     sel_pc;
   logic      sel_valid;
   logic      misaligned;
   logic      latch_set;
   logic      latch_clear;

   assign running = (state != PC_STATE_IDLE);
   assign advance = bus.inst_ready & ~bus.stall;

   always_comb begin
      src    = SRC_NONE;
      sel_pc = pc_q;
      if (running) begin
         if (bus.flush) begin
            src    = SRC_FLUSH;
            sel_pc = bus.flush_pc;
         end else if (advance) begin
            if (pending) begin
               src    = SRC_PEND;
               sel_pc = pend_addr;
            end else if (bus.branch_flag) begin
               src    = SRC_BRANCH;
               sel_pc = bus.branch_addr;
            end else begin
               src    = SRC_SEQ;
               sel_pc = pc_q + 32'd4;
            end
         end
      end
   end

   assign sel_valid = (src != SRC_NONE);

`ifdef PC_ALIGN_CHECK_EN
   logic  addr_err_q;
   addr_t bad_addr_q;

   assign misaligned = sel_valid & addr_misaligned(sel_pc);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_err_q <= 1'b0;
         bad_addr_q <= '0;
      end else begin
         addr_err_q <= misaligned;
         if (misaligned) begin
            bad_addr_q <= sel_pc;
         end
      end
   end

   assign bus.addr_err = addr_err_q;
   assign bus.bad_addr = bad_addr_q;
`else
   assign misaligned   = 1'b0;
   assign bus.addr_err = 1'b0;
   assign bus.bad_addr = '0;
`endif

   assign latch_set   = running & ~bus.flush & ~advance & bus.branch_flag & ~pending;
   assign latch_clear = running & (bus.flush | (advance & pending) | misaligned);

   branch_latch u_branch_latch (
      .clk       (clk),
      .rst       (rst),
      .set       (latch_set),
      .set_addr  (bus.branch_addr),
      .clear     (latch_clear),
      .pending   (pending),
      .pend_addr (pend_addr)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= PC_STATE_IDLE;
         pc_q     <= RESET_PC;
         rom_en_q <= 1'b0;
      end else begin
         case (state)
            PC_STATE_IDLE: begin
               state    <= PC_STATE_FETCH;
               pc_q     <= RESET_PC;
               rom_en_q <= 1'b1;
            end
            default: begin
               rom_en_q <= 1'b1;
               if (sel_valid) begin
                  pc_q <= misaligned ? EXC_VECTOR : sel_pc;
               end
               state <= (bus.flush || advance) ? PC_STATE_FETCH : PC_STATE_HOLD;
            end
         endcase
      end
   end

   assign bus.rom_en   = rom_en_q;
   assign bus.rom_addr = pc_q;
   assign bus.pc       = pc_q;
   assign bus.pending  = pending;
   assign bus.pc_valid = rom_en_q & bus.inst_ready & ~bus.stall & ~bus.flush;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: reset, sequential fetch, branch, buffered branch, flush priority, wrap, ROM wait, alignment.
module tb_fetch_pc_gen;
   import fetch_pc_gen_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   fetch_pc_gen_if bus ();

   fetch_pc_gen dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.stall = 1'b0; bus.inst_ready = 1'b1; bus.branch_flag = 1'b0;
      bus.branch_addr = '0; bus.flush = 1'b0; bus.flush_pc = '0;
      #12;
      checks++; if (bus.rom_en !== 1'b0) begin failures++; $display("FAIL reset_rom_en got=%b exp=0", bus.rom_en); end
      checks++; if (bus.pc !== 32'hBFC00000) begin failures++; $display("FAIL reset_pc got=%h exp=bfc00000", bus.pc); end
      checks++; if (bus.pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", bus.pending); end
      checks++; if (bus.addr_err !== 1'b0 || bus.bad_addr !== 32'h0) begin failures++; $display("FAIL reset_err got=%b/%h exp=0/0", bus.addr_err, bus.bad_addr); end
      rst = 1'b0;
      #1;
      checks++; if (bus.rom_en !== 1'b0 || bus.pc_valid !== 1'b0) begin failures++; $display("FAIL idle_rom_en got=%b/%b exp=0/0", bus.rom_en, bus.pc_valid); end
      step();
      checks++; if (bus.rom_en !== 1'b1 || bus.rom_addr !== 32'hBFC00000) begin failures++; $display("FAIL first_fetch got=%b/%h exp=1/bfc00000", bus.rom_en, bus.rom_addr); end
      checks++; if (bus.pc_valid !== 1'b1) begin failures++; $display("FAIL first_pc_valid got=%b exp=1", bus.pc_valid); end
   endtask

   task automatic test_sequential;
      step();
      checks++; if (bus.rom_addr !== 32'hBFC00004) begin failures++; $display("FAIL seq1 got=%h exp=bfc00004", bus.rom_addr); end
      step();
      checks++; if (bus.rom_addr !== 32'hBFC00008) begin failures++; $display("FAIL seq2 got=%h exp=bfc00008", bus.rom_addr); end
   endtask

   task automatic test_branch;
      bus.branch_flag = 1'b1; bus.branch_addr = 32'hBFC00100;
      step();
      bus.branch_flag = 1'b0;
      checks++; if (bus.rom_addr !== 32'hBFC00100 || bus.pending !== 1'b0) begin failures++; $display("FAIL branch_target got=%h/%b exp=bfc00100/0", bus.rom_addr, bus.pending); end
      step();
      checks++; if (bus.rom_addr !== 32'hBFC00104) begin failures++; $display("FAIL branch_next got=%h exp=bfc00104", bus.rom_addr); end
   endtask

   task automatic test_stall_branch;
      bus.stall = 1'b1; bus.branch_flag = 1'b1; bus.branch_addr = 32'hBFC00200;
      #1;
      checks++; if (bus.pc_valid !== 1'b0) begin failures++; $display("FAIL stall_pc_valid got=%b exp=0", bus.pc_valid); end
      step();
      checks++; if (bus.pc !== 32'hBFC00104 || bus.pending !== 1'b1) begin failures++; $display("FAIL stall1 got=%h/%b exp=bfc00104/1", bus.pc, bus.pending); end
      bus.branch_addr = 32'hBFC00300;
      step();
      checks++; if (bus.pc !== 32'hBFC00104 || bus.pending !== 1'b1) begin failures++; $display("FAIL stall2 got=%h/%b exp=bfc00104/1", bus.pc, bus.pending); end
      bus.branch_addr = 32'hBFC00200;
      step();
      checks++; if (bus.pc !== 32'hBFC00104 || bus.pending !== 1'b1) begin failures++; $display("FAIL stall3 got=%h/%b exp=bfc00104/1", bus.pc, bus.pending); end
      bus.stall = 1'b0; bus.branch_flag = 1'b0;
      #1;
      checks++; if (bus.pc_valid !== 1'b1) begin failures++; $display("FAIL unstall_pc_valid got=%b exp=1", bus.pc_valid); end
      step();
      checks++; if (bus.rom_addr !== 32'hBFC00200 || bus.pending !== 1'b0) begin failures++; $display("FAIL pend_redirect got=%h/%b exp=bfc00200/0", bus.rom_addr, bus.pending); end
      step();
      checks++; if (bus.rom_addr !== 32'hBFC00204) begin failures++; $display("FAIL pend_next got=%h exp=bfc00204", bus.rom_addr); end
   endtask

   task automatic test_flush_priority;
      bus.stall = 1'b1; bus.branch_flag = 1'b1; bus.branch_addr = 32'hBFC00400;
      step();
      checks++; if (bus.pending !== 1'b1 || bus.pc !== 32'hBFC00204) begin failures++; $display("FAIL flush_setup got=%b/%h exp=1/bfc00204", bus.pending, bus.pc); end
      bus.flush = 1'b1; bus.flush_pc = 32'hBFC00380;
      #1;
      checks++; if (bus.pc_valid !== 1'b0) begin failures++; $display("FAIL flush_pc_valid got=%b exp=0", bus.pc_valid); end
      step();
      bus.flush = 1'b0; bus.stall = 1'b0; bus.branch_flag = 1'b0;
      checks++; if (bus.rom_addr !== 32'hBFC00380 || bus.pending !== 1'b0) begin failures++; $display("FAIL flush_target got=%h/%b exp=bfc00380/0", bus.rom_addr, bus.pending); end
      step();
      checks++; if (bus.rom_addr !== 32'hBFC00384) begin failures++; $display("FAIL flush_next got=%h exp=bfc00384", bus.rom_addr); end
   endtask

   task automatic test_wrap_and_wait;
      bus.flush = 1'b1; bus.flush_pc = 32'hFFFFFFFC;
      step();
      bus.flush = 1'b0;
      checks++; if (bus.rom_addr !== 32'hFFFFFFFC) begin failures++; $display("FAIL wrap_setup got=%h exp=fffffffc", bus.rom_addr); end
      step();
      checks++; if (bus.rom_addr !== 32'h00000000) begin failures++; $display("FAIL wrap got=%h exp=00000000", bus.rom_addr); end
      bus.inst_ready = 1'b0;
      #1;
      checks++; if (bus.pc_valid !== 1'b0) begin failures++; $display("FAIL wait_pc_valid got=%b exp=0", bus.pc_valid); end
      step();
      checks++; if (bus.pc !== 32'h0 || bus.pc_valid !== 1'b0) begin failures++; $display("FAIL wait1 got=%h/%b exp=00000000/0", bus.pc, bus.pc_valid); end
      step();
      checks++; if (bus.pc !== 32'h0) begin failures++; $display("FAIL wait2 got=%h exp=00000000", bus.pc); end
      bus.inst_ready = 1'b1;
      step();
      checks++; if (bus.pc !== 32'h4) begin failures++; $display("FAIL wait_release got=%h exp=00000004", bus.pc); end
      bus.stall = 1'b1; bus.inst_ready = 1'b0;
      step();
      checks++; if (bus.pc !== 32'h4) begin failures++; $display("FAIL double_hold got=%h exp=00000004", bus.pc); end
      bus.stall = 1'b0; bus.inst_ready = 1'b1;
      step();
      checks++; if (bus.pc !== 32'h8) begin failures++; $display("FAIL double_release got=%h exp=00000008", bus.pc); end
   endtask

   task automatic test_misaligned;
      bus.branch_flag = 1'b1; bus.branch_addr = 32'hBFC00102;
      step();
      bus.branch_flag = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      checks++; if (bus.rom_addr !== 32'hBFC00380 || bus.addr_err !== 1'b1) begin failures++; $display("FAIL align_trap got=%h/%b exp=bfc00380/1", bus.rom_addr, bus.addr_err); end
      checks++; if (bus.bad_addr !== 32'hBFC00102) begin failures++; $display("FAIL align_bad got=%h exp=bfc00102", bus.bad_addr); end
      step();
      checks++; if (bus.addr_err !== 1'b0 || bus.bad_addr !== 32'hBFC00102 || bus.rom_addr !== 32'hBFC00384) begin failures++; $display("FAIL align_after got=%b/%h/%h exp=0/bfc00102/bfc00384", bus.addr_err, bus.bad_addr, bus.rom_addr); end
`else
      checks++; if (bus.rom_addr !== 32'hBFC00102 || bus.addr_err !== 1'b0 || bus.bad_addr !== 32'h0) begin failures++; $display("FAIL noalign got=%h/%b/%h exp=bfc00102/0/0", bus.rom_addr, bus.addr_err, bus.bad_addr); end
      step();
      checks++; if (bus.rom_addr !== 32'hBFC00106 || bus.addr_err !== 1'b0) begin failures++; $display("FAIL noalign_next got=%h/%b exp=bfc00106/0", bus.rom_addr, bus.addr_err); end
`endif
   endtask

   task automatic test_reset_mid_hold;
      bus.stall = 1'b1; bus.branch_flag = 1'b1; bus.branch_addr = 32'hBFC00500;
      step();
      checks++; if (bus.pending !== 1'b1) begin failures++; $display("FAIL hold_pending got=%b exp=1", bus.pending); end
      rst = 1'b1;
      #1;
      checks++; if (bus.pending !== 1'b0 || bus.pc !== 32'hBFC00000 || bus.rom_en !== 1'b0) begin failures++; $display("FAIL async_rst got=%b/%h/%b exp=0/bfc00000/0", bus.pending, bus.pc, bus.rom_en); end
      #2;
      rst = 1'b0; bus.stall = 1'b0; bus.branch_flag = 1'b0;
      step();
      checks++; if (bus.rom_en !== 1'b1 || bus.rom_addr !== 32'hBFC00000) begin failures++; $display("FAIL rst_refetch got=%b/%h exp=1/bfc00000", bus.rom_en, bus.rom_addr); end
      step();
      checks++; if (bus.rom_addr !== 32'hBFC00004 || bus.pending !== 1'b0) begin failures++; $display("FAIL rst_discard got=%h/%b exp=bfc00004/0", bus.rom_addr, bus.pending); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_sequential();
      test_branch();
      test_stall_branch();
      test_flush_priority();
      test_wrap_and_wait();
      test_misaligned();
      test_reset_mid_hold();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
